// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive path: default sizing, the 3-input
// majority helper and the receive FSM state encoding.
package uart_rx_pkg;

    localparam int PRESCALE_DEF = 16;
    localparam int BIT_W_DEF    = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/rx_edge_bit_sampler_if.sv
// Link between the receive FSM (master) and the oversampling front end (slave).
interface rx_edge_bit_sampler_if
    import uart_rx_pkg::*;
#(
    parameter int EDGE_W = $clog2(PRESCALE_DEF),
    parameter int BIT_W  = BIT_W_DEF
);
    logic              edge_bit_enable;
    logic              data_sampler_enable;
    logic [EDGE_W-1:0] edge_count;
    logic [BIT_W-1:0]  bit_count;
    logic              sampled_bit;
    logic              sample_valid;
    logic              sample_noisy;

    modport master (
        output edge_bit_enable, data_sampler_enable,
        input  edge_count, bit_count, sampled_bit, sample_valid, sample_noisy
    );

    modport slave (
        input  edge_bit_enable, data_sampler_enable,
        output edge_count, bit_count, sampled_bit, sample_valid, sample_noisy
    );
endinterface

// File: rtl/rx_sync2.sv
// Two-flop synchroniser for the raw serial line; resets to the idle level.
module rx_sync2 (
    input  logic CLK,
    input  logic RST,
    input  logic d,
    output logic q
);
    logic [1:0] chain_reg;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            chain_reg <= 2'b11;
        end else begin
            chain_reg <= {chain_reg[0], d};
        end
    end

    assign q = chain_reg[1];
endmodule

// File: rtl/rx_edge_bit_sampler.sv
// Oversampling front end of the UART receiver: edge/bit counters plus a
// 3-point majority vote around mid-bit, one clean bit per bit period.
module rx_edge_bit_sampler
    import uart_rx_pkg::*;
#(
    parameter int PRESCALE = PRESCALE_DEF,
    parameter int EDGE_W   = $clog2(PRESCALE),
    parameter int BIT_W    = BIT_W_DEF
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    rx_edge_bit_sampler_if.slave  bus
);
    localparam int M = PRESCALE / 2;
    localparam logic [EDGE_W-1:0] EDGE_LAST  = EDGE_W'(PRESCALE - 1);
    localparam logic [EDGE_W-1:0] EDGE_FIRST = EDGE_W'(M - 1);
    localparam logic [EDGE_W-1:0] EDGE_VOTE  = EDGE_W'(M + 2);
    localparam logic [BIT_W-1:0]  BIT_MAX    = '1;

    logic              rx_sync;
    logic [EDGE_W-1:0] edge_count_reg;
    logic [BIT_W-1:0]  bit_count_reg;
    logic [2:0]        s_vec;
    logic              sampled_bit_reg;
    logic              sample_valid_reg;
    logic              sample_noisy_reg;
    logic              aborted_reg;

    rx_sync2 u_sync (
        .CLK (CLK),
        .RST (RST),
        .d   (RX_IN),
        .q   (rx_sync)
    );

    // A drop of the enable clears the counters even on a wrap cycle.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            edge_count_reg <= '0;
            bit_count_reg  <= '0;
        end else if (!bus.edge_bit_enable) begin
            edge_count_reg <= '0;
            bit_count_reg  <= '0;
        end else if (edge_count_reg == EDGE_LAST) begin
            edge_count_reg <= '0;
            if (bit_count_reg != BIT_MAX) begin
                bit_count_reg <= bit_count_reg + BIT_W'(1);
            end
        end else begin
            edge_count_reg <= edge_count_reg + EDGE_W'(1);
        end
    end

    // Sample gi is taken at edge M-1+gi; any sampler disable returns it to idle.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_samp
            logic s_reg;

            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    s_reg <= 1'b1;
                end else if (!bus.data_sampler_enable) begin
                    s_reg <= 1'b1;
                end else if (edge_count_reg == EDGE_W'(M - 1 + gi)) begin
                    s_reg <= rx_sync;
                end
            end

            assign s_vec[gi] = s_reg;
        end
    endgenerate

    // aborted_reg blocks the vote for a window the sampler was not enabled across.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sampled_bit_reg  <= 1'b1;
            sample_valid_reg <= 1'b0;
            sample_noisy_reg <= 1'b0;
            aborted_reg      <= 1'b1;
        end else begin
            sample_valid_reg <= 1'b0;
            sample_noisy_reg <= 1'b0;
            if (!bus.data_sampler_enable) begin
                aborted_reg <= 1'b1;
            end else if (edge_count_reg == EDGE_FIRST) begin
                aborted_reg <= 1'b0;
            end else if (edge_count_reg == EDGE_VOTE && !aborted_reg) begin
                sampled_bit_reg  <= maj3(s_vec[0], s_vec[1], s_vec[2]);
                sample_valid_reg <= 1'b1;
                sample_noisy_reg <= !(s_vec == 3'b000 || s_vec == 3'b111);
            end
        end
    end

    assign bus.edge_count   = edge_count_reg;
    assign bus.bit_count    = bit_count_reg;
    assign bus.sampled_bit  = sampled_bit_reg;
    assign bus.sample_valid = sample_valid_reg;
    assign bus.sample_noisy = sample_noisy_reg;
endmodule

// File: tb/tb_rx_edge_bit_sampler.sv
// Randomised bench for rx_edge_bit_sampler against a cycle-history reference model.
module tb_rx_edge_bit_sampler;
    localparam int P    = 16;
    localparam int M    = P / 2;
    localparam int EW   = 4;
    localparam int BW   = 5;
    localparam int BMAX = 31;
    localparam int MAXC = 8192;

    logic CLK   = 1'b0;
    logic RST   = 1'b1;
    logic RX_IN = 1'b1;

    rx_edge_bit_sampler_if #(.EDGE_W(EW), .BIT_W(BW)) bus ();

    rx_edge_bit_sampler #(.PRESCALE(P), .EDGE_W(EW), .BIT_W(BW)) dut (
        .CLK   (CLK),
        .RST   (RST),
        .RX_IN (RX_IN),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    int n_vec = 0;
    int n_err = 0;

    // Model: per-cycle history of the line (as seen after reset gating) and sampler enable.
    bit rx_hist [MAXC];
    bit dse_hist[MAXC];
    int cyc   = 0;
    int run_n = 0;
    int e_edge = 0, e_bit = 0;
    bit e_sb = 1'b1, e_valid = 1'b0, e_noisy = 1'b0;

    int valid_cnt;
    bit sb_seq[$];
    bit nz_seq[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic bit rxs(input int i);
        return (i >= 2) ? rx_hist[i-2] : 1'b1;
    endfunction

    function automatic bit frame_bit(input logic [7:0] data, input int i);
        logic [9:0] f;
        f = {1'b1, data, 1'b0};
        return f[i];
    endfunction

    // Applies one cycle of inputs, advances the model, checks every output next cycle.
    task automatic step(input bit rx, input bit ebe, input bit dse);
        int edge_c;
        int ones;
        if (cyc >= MAXC) begin
            $display("FAIL cycle_budget: got %0d cycles, expected < %0d", cyc, MAXC);
            $fatal(1);
        end
        RX_IN = rx;
        bus.edge_bit_enable     = ebe;
        bus.data_sampler_enable = dse;
        rx_hist[cyc]  = RST ? 1'b1 : rx;
        dse_hist[cyc] = RST ? 1'b0 : dse;
        if (RST) begin
            run_n   = 0;
            e_sb    = 1'b1;
            e_valid = 1'b0;
            e_noisy = 1'b0;
        end else begin
            edge_c  = run_n % P;
            e_valid = 1'b0;
            e_noisy = 1'b0;
            if (edge_c == M + 2 && dse_hist[cyc] && dse_hist[cyc-1] &&
                dse_hist[cyc-2] && dse_hist[cyc-3]) begin
                ones = int'(rxs(cyc-3)) + int'(rxs(cyc-2)) + int'(rxs(cyc-1));
                e_sb    = (ones >= 2);
                e_valid = 1'b1;
                e_noisy = (ones == 1 || ones == 2);
            end
            run_n = ebe ? run_n + 1 : 0;
        end
        e_edge = run_n % P;
        e_bit  = (run_n / P > BMAX) ? BMAX : run_n / P;
        cyc++;
        @(negedge CLK);
        check("edge_count",   bus.edge_count,   e_edge);
        check("bit_count",    bus.bit_count,    e_bit);
        check("sampled_bit",  bus.sampled_bit,  e_sb);
        check("sample_valid", bus.sample_valid, e_valid);
        check("sample_noisy", bus.sample_noisy, e_noisy);
        if (bus.sample_valid === 1'b1) begin
            valid_cnt++;
            sb_seq.push_back(bus.sampled_bit);
            nz_seq.push_back(bus.sample_noisy);
        end
    endtask

    task automatic clear_obs();
        valid_cnt = 0;
        sb_seq.delete();
        nz_seq.delete();
    endtask

    // gb/ge: bit and edge where the raw line is inverted; ab/ae: sampler off from that point of bit ab.
    task automatic run_frame(input logic [7:0] data, input int gb, input int ge,
                             input int ab, input int ae, input int gap);
        int b, e;
        bit rx, dse;
        clear_obs();
        for (int j = 0; j < 10 * P; j++) begin
            b   = j / P;
            e   = j % P;
            rx  = frame_bit(data, b) ^ (b == gb && e == ge);
            dse = !(b == ab && e >= ae);
            step(rx, 1'b1, dse);
        end
        for (int g = 0; g < gap; g++) step(1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        int nz;
        logic [7:0] d;
        bus.edge_bit_enable     = 1'b0;
        bus.data_sampler_enable = 1'b0;
        @(negedge CLK);

        // Reset held with the line toggling, then idle and a stuck-counter sampler.
        clear_obs();
        for (int i = 0; i < 6; i++) step(1'($urandom), 1'($urandom), 1'($urandom));
        RST = 1'b0;
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step(1'($urandom), 1'b0, 1'b1);
        check("idle_pulses", valid_cnt, 0);

        // Clean 0x55 frame.
        run_frame(8'h55, 99, 0, 99, 0, 4);
        check("clean_pulses", valid_cnt, 10);
        nz = 0;
        for (int i = 0; i < sb_seq.size() && i < 10; i++) begin
            check("clean_bit", sb_seq[i], frame_bit(8'h55, i));
            nz += int'(nz_seq[i]);
        end
        check("clean_noisy", nz, 0);

        // Single-cycle low glitch landing on the mid sample of a '1' bit.
        run_frame(8'h55, 1, 6, 99, 0, 4);
        check("glitch_pulses", valid_cnt, 10);
        if (sb_seq.size() > 1) begin
            check("glitch_bit",   sb_seq[1], 1);
            check("glitch_noisy", nz_seq[1], 1);
        end

        // Counter wrap and clear-wins-over-wrap.
        for (int i = 0; i < 3 * P + 5; i++) step(1'b1, 1'b1, 1'b0);
        check("wrap_edge", bus.edge_count, 5);
        check("wrap_bit",  bus.bit_count,  3);
        for (int i = 0; i < P && bus.edge_count != 4'(P - 1); i++) step(1'b1, 1'b1, 1'b0);
        check("wrap_at_last", bus.edge_count, P - 1);
        step(1'b1, 1'b0, 1'b0);
        check("clear_edge", bus.edge_count, 0);
        check("clear_bit",  bus.bit_count,  0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);

        // Sampler dropped mid-vote on bit 3, re-enabled for bit 4.
        run_frame(8'h55, 99, 0, 3, 8, 4);
        check("abort_pulses", valid_cnt, 9);
        if (sb_seq.size() > 3) check("abort_next_bit", sb_seq[3], frame_bit(8'h55, 4));

        // Asynchronous reset mid-frame, then bit counter saturation.
        for (int i = 0; i < 4 * P + 9; i++) step(1'b0, 1'b1, 1'b1);
        check("pre_rst_edge", bus.edge_count, 9);
        check("pre_rst_bit",  bus.bit_count,  4);
        #2 RST = 1'b1;
        #1;
        check("arst_edge",  bus.edge_count,   0);
        check("arst_bit",   bus.bit_count,    0);
        check("arst_sb",    bus.sampled_bit,  1);
        check("arst_valid", bus.sample_valid, 0);
        check("arst_noisy", bus.sample_noisy, 0);
        #1;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1);
        RST = 1'b0;
        clear_obs();
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0);
        check("rst_release_pulses", valid_cnt, 0);
        for (int i = 0; i < 40 * P; i++) step(1'b1, 1'b1, 1'b0);
        check("sat_bit", bus.bit_count, BMAX);
        step(1'b1, 1'b0, 1'b0);

        // Random frames with random glitches and sampler drops.
        for (int k = 0; k < 6; k++) begin
            d = 8'($urandom);
            run_frame(d, $urandom_range(0, 14), $urandom_range(0, 15),
                      $urandom_range(0, 14), $urandom_range(0, 15), $urandom_range(1, 6));
        end

        // Unstructured random burst.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), ($urandom_range(0, 19) != 0), ($urandom_range(0, 9) != 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
